// File: rtl/mac_sim_pkg.sv
// rtl/mac_sim_pkg.sv - shared types and constants for the MAC transmit sink model
//
// Purpose: FSM state encoding, frame status codes, byte-count width and a
//          saturating increment helper used by mac_tx_sink and its sub-modules.
// Ports:   none (package).
package mac_sim_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    STAT_OK        = 3'd0,
    STAT_PATTERN   = 3'd1,
    STAT_ERR_FLAG  = 3'd2,
    STAT_OVERSIZE  = 3'd3,
    STAT_TRUNCATED = 3'd4
  } status_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mac_bp_gen.sv
// rtl/mac_bp_gen.sv - cyclic backpressure generator producing a registered ready
//
// Purpose: 3-bit free-running phase counter; ready follows BP_PATTERN[phase].
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - asynchronous active-high reset (phase=0, rdy=BP_PATTERN[0])
//   o_rdy  - registered ready, equal to BP_PATTERN[phase] every cycle
module mac_bp_gen #(
  parameter logic [7:0] BP_PATTERN = 8'hFF
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_rdy
);

  logic [2:0] r_phase;
  logic [2:0] w_phase_nxt;
  logic       r_rdy;

  assign w_phase_nxt = r_phase + 3'd1;

  // Ready is looked up with the phase it will hold after the edge, so the
  // register always matches BP_PATTERN[r_phase] without a combinational path.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase <= 3'd0;
      r_rdy   <= BP_PATTERN[0];
    end else begin
      r_phase <= w_phase_nxt;
      r_rdy   <= BP_PATTERN[w_phase_nxt];
    end
  end

  assign o_rdy = r_rdy;

endmodule

// File: rtl/mac_tx_sink.sv
// rtl/mac_tx_sink.sv - MAC transmit FIFO sink that checks incrementing-byte frames
//
// Purpose: accepts sop/eop framed beats under programmable backpressure, checks
//          each valid byte against seed+offset, reports length/status per frame
//          and keeps saturating good/bad/orphan counters.
// Ports:
//   i_clk, i_rst          - clock, asynchronous active-high reset
//   i_data                - beat data, byte 0 in the top byte lane
//   i_sop, i_eop          - first / last beat of a frame
//   i_err                 - frame error flag, meaningful on the eop beat only
//   i_mod                 - empty bytes on the eop beat (0 = all valid)
//   i_wren                - beat valid
//   o_rdy                 - sink ready (registered, cyclic pattern)
//   o_frame_done          - one-cycle result pulse
//   o_frame_len           - byte count of the reported frame (saturating)
//   o_frame_status        - status code of the reported frame
//   o_good_cnt, o_bad_cnt - saturating OK / non-OK frame counters
//   o_orphan_cnt          - saturating count of beats accepted outside a frame
module mac_tx_sink
  import mac_sim_pkg::*;
#(
  parameter int         DATA_W     = 32,
  parameter int         MOD_W      = $clog2(DATA_W/8),
  parameter int         MAX_FRAME  = 1518,
  parameter logic [7:0] BP_PATTERN = 8'hFF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic              i_err,
  input  logic [MOD_W-1:0]  i_mod,
  input  logic              i_wren,
  output logic              o_rdy,
  output logic              o_frame_done,
  output logic [CNT_W-1:0]  o_frame_len,
  output logic [2:0]        o_frame_status,
  output logic [CNT_W-1:0]  o_good_cnt,
  output logic [CNT_W-1:0]  o_bad_cnt,
  output logic [CNT_W-1:0]  o_orphan_cnt
);

  localparam int NB   = DATA_W/8;
  localparam int NB_W = MOD_W + 1;

  state_e             r_state, w_state_nxt;
  logic [7:0]         r_seed;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pat_err;

  logic               r_frame_done;
  logic [CNT_W-1:0]   r_frame_len;
  status_e            r_frame_status;
  logic [CNT_W-1:0]   r_good_cnt, r_bad_cnt, r_orphan_cnt;

  logic               r_hold_v;
  logic [CNT_W-1:0]   r_hold_len;
  status_e            r_hold_status;

  logic               w_rdy;
  logic               w_accept, w_in_frame, w_body, w_dropping;
  logic               w_trunc, w_fin, w_orphan, w_mismatch, w_over;
  logic [NB_W-1:0]    w_nbytes;
  logic [7:0]         w_byte0, w_base;
  logic [CNT_W-1:0]   w_cnt_base, w_cnt_new;
  logic [CNT_W:0]     w_cnt_sum;
  status_e            w_fin_status;

  logic               w_out_v, w_hold_v_nxt;
  logic [CNT_W-1:0]   w_out_len, w_hold_len_nxt;
  status_e            w_out_status, w_hold_status_nxt;

  mac_bp_gen #(.BP_PATTERN(BP_PATTERN)) u_bp_gen (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_rdy (w_rdy)
  );

  // ---------------------------------------------------------------- beat decode
  assign w_accept   = i_wren & w_rdy;
  assign w_in_frame = (r_state != ST_IDLE);
  // A beat belongs to a frame if it opens one or arrives while one is open.
  assign w_body     = w_accept & (i_sop | w_in_frame);
  assign w_dropping = (r_state == ST_DROP) & ~i_sop;
  assign w_trunc    = w_accept & i_sop & w_in_frame;
  assign w_fin      = w_body & i_eop;
  assign w_orphan   = w_accept & ~i_sop & ~w_in_frame;

  assign w_nbytes   = i_eop ? (NB_W'(NB) - NB_W'(i_mod)) : NB_W'(NB);
  assign w_byte0    = i_data[DATA_W-1 -: 8];
  assign w_base     = i_sop ? w_byte0 : (r_seed + r_cnt[7:0]);

  assign w_cnt_base = i_sop ? '0 : r_cnt;
  assign w_cnt_sum  = {1'b0, w_cnt_base} + (CNT_W+1)'(w_nbytes);
  assign w_cnt_new  = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
  assign w_over     = int'(w_cnt_new) > MAX_FRAME;

  // One comparator per byte lane; lanes beyond the valid count are ignored.
  always_comb begin
    w_mismatch = 1'b0;
    for (int j = 0; j < NB; j++) begin
      if ((NB_W'(j) < w_nbytes) && (i_data[DATA_W-1-8*j -: 8] != (w_base + 8'(j)))) begin
        w_mismatch = 1'b1;
      end
    end
  end

  always_comb begin
    if (w_dropping || w_over) begin
      w_fin_status = STAT_OVERSIZE;
    end else if (i_err) begin
      w_fin_status = STAT_ERR_FLAG;
    end else if ((r_pat_err && !i_sop) || w_mismatch) begin
      w_fin_status = STAT_PATTERN;
    end else begin
      w_fin_status = STAT_OK;
    end
  end

  // ------------------------------------------------------------------------ FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_body) begin
      if (i_eop) begin
        w_state_nxt = ST_IDLE;
      end else if (w_dropping || w_over) begin
        w_state_nxt = ST_DROP;
      end else begin
        w_state_nxt = ST_FRAME;
      end
    end
  end

  // -------------------------------------------------------------- frame tracking
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seed    <= 8'd0;
      r_cnt     <= '0;
      r_pat_err <= 1'b0;
    end else if (w_body) begin
      r_cnt     <= w_cnt_new;
      r_pat_err <= (r_pat_err & ~i_sop) | (w_mismatch & ~w_dropping);
      if (i_sop) begin
        r_seed <= w_byte0;
      end
    end
  end

  // ------------------------------------------------------------ result ordering
  // A truncating sop+eop beat yields two results at once; the second waits one
  // cycle in the hold register. Such a beat leaves the FSM idle, so while the
  // hold register is occupied at most one new result can arrive per cycle.
  always_comb begin
    w_out_v           = 1'b0;
    w_out_len         = r_hold_len;
    w_out_status      = r_hold_status;
    w_hold_v_nxt      = 1'b0;
    w_hold_len_nxt    = r_hold_len;
    w_hold_status_nxt = r_hold_status;
    if (r_hold_v) begin
      w_out_v      = 1'b1;
      w_hold_v_nxt = w_trunc | w_fin;
      if (w_trunc) begin
        w_hold_len_nxt    = r_cnt;
        w_hold_status_nxt = STAT_TRUNCATED;
      end else if (w_fin) begin
        w_hold_len_nxt    = w_cnt_new;
        w_hold_status_nxt = w_fin_status;
      end
    end else if (w_trunc) begin
      w_out_v           = 1'b1;
      w_out_len         = r_cnt;
      w_out_status      = STAT_TRUNCATED;
      w_hold_v_nxt      = w_fin;
      w_hold_len_nxt    = w_cnt_new;
      w_hold_status_nxt = w_fin_status;
    end else if (w_fin) begin
      w_out_v      = 1'b1;
      w_out_len    = w_cnt_new;
      w_out_status = w_fin_status;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_done   <= 1'b0;
      r_frame_len    <= '0;
      r_frame_status <= STAT_OK;
      r_good_cnt     <= '0;
      r_bad_cnt      <= '0;
      r_orphan_cnt   <= '0;
      r_hold_v       <= 1'b0;
      r_hold_len     <= '0;
      r_hold_status  <= STAT_OK;
    end else begin
      r_frame_done  <= w_out_v;
      r_hold_v      <= w_hold_v_nxt;
      r_hold_len    <= w_hold_len_nxt;
      r_hold_status <= w_hold_status_nxt;
      if (w_out_v) begin
        r_frame_len    <= w_out_len;
        r_frame_status <= w_out_status;
        if (w_out_status == STAT_OK) begin
          r_good_cnt <= sat_inc(r_good_cnt);
        end else begin
          r_bad_cnt <= sat_inc(r_bad_cnt);
        end
      end
      if (w_orphan) begin
        r_orphan_cnt <= sat_inc(r_orphan_cnt);
      end
    end
  end

  assign o_rdy          = w_rdy;
  assign o_frame_done   = r_frame_done;
  assign o_frame_len    = r_frame_len;
  assign o_frame_status = r_frame_status;
  assign o_good_cnt     = r_good_cnt;
  assign o_bad_cnt      = r_bad_cnt;
  assign o_orphan_cnt   = r_orphan_cnt;

endmodule

// File: tb/tb_mac_tx_sink.sv
// tb/tb_mac_tx_sink.sv - self-checking bench for mac_tx_sink
module tb_mac_tx_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic        sop, eop, err, wren;
  logic [1:0]  mod;
  int          sel;
  logic [2:0]  wren_v;

  logic        rdy_o  [3];
  logic        done_o [3];
  logic [15:0] len_o  [3];
  logic [2:0]  stat_o [3];
  logic [15:0] good_o [3];
  logic [15:0] bad_o  [3];
  logic [15:0] orph_o [3];

  int n_checks = 0;
  int n_err    = 0;
  int done_seen [3] = '{0, 0, 0};
  int exp_good  [3] = '{0, 0, 0};
  int exp_bad   [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  assign wren_v = wren ? (3'b001 << sel) : 3'b000;

  // dut 0: defaults; dut 1: alternating ready; dut 2: small MAX_FRAME
  mac_tx_sink #(.DATA_W(32), .MAX_FRAME(1518), .BP_PATTERN(8'hFF)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_sop(sop), .i_eop(eop), .i_err(err),
    .i_mod(mod), .i_wren(wren_v[0]), .o_rdy(rdy_o[0]), .o_frame_done(done_o[0]),
    .o_frame_len(len_o[0]), .o_frame_status(stat_o[0]), .o_good_cnt(good_o[0]),
    .o_bad_cnt(bad_o[0]), .o_orphan_cnt(orph_o[0]));

  mac_tx_sink #(.DATA_W(32), .MAX_FRAME(1518), .BP_PATTERN(8'b01010101)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_sop(sop), .i_eop(eop), .i_err(err),
    .i_mod(mod), .i_wren(wren_v[1]), .o_rdy(rdy_o[1]), .o_frame_done(done_o[1]),
    .o_frame_len(len_o[1]), .o_frame_status(stat_o[1]), .o_good_cnt(good_o[1]),
    .o_bad_cnt(bad_o[1]), .o_orphan_cnt(orph_o[1]));

  mac_tx_sink #(.DATA_W(32), .MAX_FRAME(64), .BP_PATTERN(8'hFF)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_sop(sop), .i_eop(eop), .i_err(err),
    .i_mod(mod), .i_wren(wren_v[2]), .o_rdy(rdy_o[2]), .o_frame_done(done_o[2]),
    .o_frame_len(len_o[2]), .o_frame_status(stat_o[2]), .o_good_cnt(good_o[2]),
    .o_bad_cnt(bad_o[2]), .o_orphan_cnt(orph_o[2]));

  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 3; k++) begin
      if (done_o[k] === 1'b1) done_seen[k]++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] gen_beat(input logic [7:0] seed, input int b, input int bad);
    logic [31:0] d;
    logic [7:0]  v;
    int          idx;
    d = '0;
    for (int j = 0; j < 4; j++) begin
      idx = 4*b + j;
      v = seed + 8'(idx);
      if (idx == bad) v = v ^ 8'h5A;
      d[31-8*j -: 8] = v;
    end
    return d;
  endfunction

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [31:0] d, input bit s, input bit e, input bit er,
                           input logic [1:0] m);
    int guard = 0;
    while (rdy_o[sel] !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) begin
      n_checks++;
      n_err++;
      $display("FAIL rdy_timeout: got 0 expected 1");
    end
    data = d; sop = s; eop = e; err = er; mod = m; wren = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wren = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0;
    @(negedge clk);
  endtask

  // err is raised on beat 1 and mod is garbage on non-eop beats; both must be ignored.
  task automatic send_frame(input int nb, input logic [7:0] seed, input int m, input int bad,
                            input bit er, input bit with_eop);
    bit last, e;
    for (int b = 0; b < nb; b++) begin
      last = (b == nb - 1);
      e    = last && with_eop;
      send_beat(gen_beat(seed, b, bad), (b == 0), e, e ? er : (b == 1), e ? 2'(m) : 2'(b));
    end
  endtask

  typedef struct {
    int         sel;
    logic [7:0] seed;
    int         nb;
    int         m;
    int         bad;
    bit         er;
    int         len;
    int         st;
  } vec_t;

  vec_t tbl [13];
  int   snap;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 8'h00, 52, 0,  -1, 1'b0, 208, 0};
    tbl[1]  = '{0, 8'h00, 52, 2,  -1, 1'b0, 206, 0};
    tbl[2]  = '{0, 8'h00, 52, 0, 100, 1'b0, 208, 1};
    tbl[3]  = '{0, 8'hF0, 52, 0,  -1, 1'b1, 208, 2};
    tbl[4]  = '{0, 8'hFE,  3, 1,  11, 1'b0,  11, 0};
    tbl[5]  = '{0, 8'h33,  1, 3,  -1, 1'b0,   1, 0};
    tbl[6]  = '{0, 8'h10,  4, 0,   5, 1'b1,  16, 2};
    tbl[7]  = '{0, 8'h20,  2, 3,   4, 1'b0,   5, 1};
    tbl[8]  = '{1, 8'h00, 52, 0,  -1, 1'b0, 208, 0};
    tbl[9]  = '{2, 8'h00, 20, 0,  -1, 1'b0,  80, 3};
    tbl[10] = '{2, 8'h07,  4, 0,  -1, 1'b0,  16, 0};
    tbl[11] = '{2, 8'h00, 16, 0,  -1, 1'b0,  64, 0};
    tbl[12] = '{2, 8'h00, 17, 0,  -1, 1'b0,  68, 3};

    rst = 1'b1; data = '0; sop = 0; eop = 0; err = 0; mod = '0; wren = 0; sel = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset values
    chk("rst_rdy_a", rdy_o[0], 1);
    chk("rst_rdy_b", rdy_o[1], 1);
    chk("rst_done", done_o[0], 0);
    chk("rst_len", len_o[0], 0);
    chk("rst_status", stat_o[0], 0);
    chk("rst_good", good_o[0], 0);
    chk("rst_bad", bad_o[0], 0);
    chk("rst_orphan", orph_o[0], 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("phase%0d_rdy_b", i), rdy_o[1], (i % 2 == 0) ? 1 : 0);
      chk($sformatf("phase%0d_rdy_a", i), rdy_o[0], 1);
      @(negedge clk);
    end

    // table-driven frames, back to back on the same dut
    for (int i = 0; i < 13; i++) begin
      if (i > 0 && tbl[i].sel != tbl[i-1].sel) begin
        idle();
        sel = tbl[i].sel;
      end
      send_frame(tbl[i].nb, tbl[i].seed, tbl[i].m, tbl[i].bad, tbl[i].er, 1'b1);
      if (tbl[i].st == 0) exp_good[sel]++;
      else                exp_bad[sel]++;
      chk($sformatf("vec%0d_done", i), done_o[sel], 1);
      chk($sformatf("vec%0d_len", i), len_o[sel], tbl[i].len);
      chk($sformatf("vec%0d_status", i), stat_o[sel], tbl[i].st);
      chk($sformatf("vec%0d_good", i), good_o[sel], exp_good[sel]);
      chk($sformatf("vec%0d_bad", i), bad_o[sel], exp_bad[sel]);
    end
    idle();
    chk("done_pulse_width", done_o[2], 0);
    sel = 0;

    // sop at beat 10 of an open frame
    send_frame(10, 8'h40, 0, -1, 1'b0, 1'b0);
    send_beat(gen_beat(8'h80, 0, -1), 1'b1, 1'b0, 1'b0, 2'd0);
    exp_bad[0]++;
    chk("trunc_done", done_o[0], 1);
    chk("trunc_status", stat_o[0], 4);
    chk("trunc_len", len_o[0], 40);
    chk("trunc_bad", bad_o[0], exp_bad[0]);
    for (int b = 1; b < 4; b++) begin
      send_beat(gen_beat(8'h80, b, -1), 1'b0, (b == 3), 1'b0, 2'd0);
    end
    exp_good[0]++;
    chk("after_trunc_status", stat_o[0], 0);
    chk("after_trunc_len", len_o[0], 16);
    chk("after_trunc_good", good_o[0], exp_good[0]);

    // truncation together with a single-beat frame on the same beat
    send_frame(3, 8'h00, 0, -1, 1'b0, 1'b0);
    send_beat(gen_beat(8'h90, 0, -1), 1'b1, 1'b1, 1'b0, 2'd0);
    chk("dual_n1_done", done_o[0], 1);
    chk("dual_n1_status", stat_o[0], 4);
    chk("dual_n1_len", len_o[0], 12);
    idle();
    exp_bad[0]++;
    exp_good[0]++;
    chk("dual_n2_done", done_o[0], 1);
    chk("dual_n2_status", stat_o[0], 0);
    chk("dual_n2_len", len_o[0], 4);
    chk("dual_good", good_o[0], exp_good[0]);
    chk("dual_bad", bad_o[0], exp_bad[0]);
    @(negedge clk);
    chk("dual_n3_done", done_o[0], 0);

    // beats without sop while idle
    snap = done_seen[0];
    send_beat(32'h01020304, 1'b0, 1'b0, 1'b0, 2'd0);
    send_beat(32'h11121314, 1'b0, 1'b1, 1'b1, 2'd1);
    send_beat(32'h21222324, 1'b0, 1'b0, 1'b0, 2'd0);
    idle();
    @(negedge clk);
    chk("orphan_cnt", orph_o[0], 3);
    chk("orphan_no_done", done_seen[0] - snap, 0);
    chk("orphan_good", good_o[0], exp_good[0]);

    // back-to-back single-beat frames
    for (int i = 0; i < 3; i++) begin
      send_beat(gen_beat(8'(8'hA0 + 8'(i)), 0, -1), 1'b1, 1'b1, 1'b0, 2'd0);
      exp_good[0]++;
      chk($sformatf("b2b%0d_done", i), done_o[0], 1);
      chk($sformatf("b2b%0d_len", i), len_o[0], 4);
      chk($sformatf("b2b%0d_good", i), good_o[0], exp_good[0]);
    end
    idle();

    // reset in the middle of a frame
    send_frame(5, 8'h55, 0, -1, 1'b0, 1'b0);
    wren = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_good", good_o[0], 0);
    chk("midrst_bad", bad_o[0], 0);
    chk("midrst_orphan", orph_o[0], 0);
    chk("midrst_done", done_o[0], 0);
    chk("midrst_len", len_o[0], 0);
    rst = 1'b0;
    @(negedge clk);
    snap = done_seen[0];
    send_frame(3, 8'h61, 0, -1, 1'b0, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    chk("postrst_done_count", done_seen[0] - snap, 1);
    chk("postrst_status", stat_o[0], 0);
    chk("postrst_len", len_o[0], 12);
    chk("postrst_good", good_o[0], 1);
    chk("postrst_bad", bad_o[0], 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_tx_sink.md
# mac_tx_sink

Parametrised simulation/checker model of the MAC transmit FIFO interface (sop/eop/err/mod/rdy/wren). It sits where the MAC core would sit, downstream of the packet generator. It accepts frames with programmable backpressure and checks each frame against the incrementing-byte test pattern. It reports a per-frame length and status, and keeps good/bad frame counters.

## Interface
- DATA_W, 32, beat width in bits; multiple of 8, 16..128
- MOD_W, derived = clog2(DATA_W/8), width of mod
- MAX_FRAME, 1518, maximum legal frame length in bytes
- BP_PATTERN, 8'hFF, 8-bit cyclic rdy pattern; bit i drives rdy in phase i
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- data  in  DATA_W  beat data; byte 0 of beat = data[DATA_W-1 -: 8]
- sop  in  1  first beat of frame
- eop  in  1  last beat of frame
- err  in  1  frame error flag, sampled on eop beat only
- mod  in  MOD_W  empty bytes on eop beat; 0 = all bytes valid
- wren  in  1  beat valid
- rdy  out  1  sink ready
- frame_done  out  1  one-cycle pulse, frame result valid
- frame_len  out  16  byte count of completed frame
- frame_status  out  3  0 OK, 1 PATTERN, 2 ERR_FLAG, 3 OVERSIZE, 4 TRUNCATED
- good_cnt  out  16  saturating count of OK frames
- bad_cnt  out  16  saturating count of non-OK frames
- orphan_cnt  out  16  saturating count of beats accepted outside a frame

## Operation
- Beat accepted on a rising edge where wren & rdy; wren without rdy is ignored, with no state change.
- rdy = BP_PATTERN[phase]. phase is a 3-bit counter that advances every cycle, independent of traffic.
- FSM states: IDLE, FRAME, DROP.
- IDLE: an accepted beat with sop enters FRAME. Seed = byte 0 of the beat. Byte count and pattern check restart. An accepted beat without sop increments orphan_cnt and the FSM stays in IDLE.
- FRAME: each valid byte k of the frame must equal (seed + k) mod 256. A mismatch latches a sticky PATTERN flag.
- Valid bytes per beat = DATA_W/8, except on the eop beat, where valid bytes = DATA_W/8 - mod. mod is ignored on non-eop beats.
- Byte count exceeding MAX_FRAME: enter DROP with OVERSIZE latched.
- DROP: beats are consumed without checking; eop completes the frame.
- sop beat in FRAME or DROP: the current frame completes as TRUNCATED with the bytes counted so far. That same beat then starts a new frame.
- sop and eop on the same beat: single-beat frame, completed immediately.
- Status priority: TRUNCATED > OVERSIZE > ERR_FLAG (err=1 on eop) > PATTERN > OK.
- Completion increments good_cnt if the status is OK, otherwise bad_cnt. All counters saturate at 16'hFFFF.
- frame_len saturates at 16'hFFFF; in DROP it keeps counting all bytes.

## Timing
- Reset values: rdy=BP_PATTERN[0], frame_done=0, frame_len=0, frame_status=0, all counters 0, FSM=IDLE, phase=0.
- rdy is registered; it is already correct in the first cycle after reset release.
- frame_done asserts in the cycle after the completing beat is accepted. frame_len and frame_status hold until the next completion.
- Back-to-back frames (eop beat immediately followed by a sop beat) give two frame_done pulses on consecutive cycles.
- TRUNCATED plus a new single-beat sop+eop frame on the same beat: TRUNCATED result in cycle N+1, new frame result in cycle N+2. One-entry result holding register.
- Reset mid-frame aborts the frame with no completion reported and clears all counters.

## Structure
- Package mac_sim_pkg holds:
  - FSM state enum
  - frame_status codes
  - byte-count width constant (16)
- Sub-module mac_bp_gen: phase counter plus BP_PATTERN lookup, producing a registered rdy. It is reused by future MAC RX source models.
- Datapath logic:
  - per-byte compare against seed+offset, unrolled over DATA_W/8 lanes
  - popcount-free valid-byte count derived from mod

## Test plan
- DATA_W=32, BP_PATTERN=FF: sop beat with bytes 00..03, 50 continuation beats, eop beat with mod=0 → frame_done one cycle later, frame_len=208, status OK, good_cnt=1.
- Same frame but eop with mod=2 → frame_len=206, status OK. Repeat with byte 100 corrupted → status PATTERN, bad_cnt=1.
- BP_PATTERN=8'b01010101 with wren held high → every other beat ignored. A correctly paced source yields frame_len=208, OK.
- MAX_FRAME=64, 20-beat frame → status OVERSIZE, frame_len=80; the following legal 4-beat frame → OK, len 16.
- sop at beat 10 of an open frame → TRUNCATED, len 40, then the new frame completes OK. Beats without sop in IDLE → orphan_cnt increments by the count of those beats.
- Assert rst mid-frame, then send a clean frame → counters 0 before that frame, exactly one frame_done, OK.
